mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) in front of a single-port 32x8 memory.
// Fetch owns words 0..15 read-only, data owns words 16..31; data has priority unless fetch is starving.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [3:0] i_addr,
    output logic       i_gnt,
    output logic       i_rvalid,
    output logic [7:0] i_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [3:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_gnt,
    output logic       d_rvalid,
    output logic [7:0] d_rdata,
    output logic [4:0] mem_addr,
    output logic       mem_w_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] i_addr_reg, i_addr_next;
    logic [3:0] d_addr_reg, d_addr_next;
    logic       d_we_reg, d_we_next;
    logic [7:0] d_wdata_reg, d_wdata_next;
    logic [2:0] starve_cnt_reg, starve_cnt_next;
    logic       i_rvalid_reg, d_rvalid_reg;
    logic [7:0] i_rdata_reg, d_rdata_reg;
    logic       i_elig, d_elig, fetch_wins;

    // A requester holding the grant this cycle sits out the next decision.
    always_comb begin
        i_elig          = i_req && (state_reg != ACC_I);
        d_elig          = d_req && (state_reg != ACC_D);
        fetch_wins      = i_elig && (!d_elig || (starve_cnt_reg == LIMIT));
        state_next      = IDLE;
        i_addr_next     = i_addr_reg;
        d_addr_next     = d_addr_reg;
        d_we_next       = d_we_reg;
        d_wdata_next    = d_wdata_reg;
        starve_cnt_next = starve_cnt_reg;
        if (fetch_wins) begin
            state_next      = ACC_I;
            i_addr_next     = i_addr;
            starve_cnt_next = 3'd0;
        end else if (d_elig) begin
            state_next   = ACC_D;
            d_addr_next  = d_addr;
            d_we_next    = d_we;
            d_wdata_next = d_wdata;
            if (i_elig && (starve_cnt_reg < LIMIT)) begin
                starve_cnt_next = starve_cnt_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            i_addr_reg     <= 4'd0;
            d_addr_reg     <= 4'd0;
            d_we_reg       <= 1'b0;
            d_wdata_reg    <= 8'd0;
            starve_cnt_reg <= 3'd0;
        end else begin
            state_reg      <= state_next;
            i_addr_reg     <= i_addr_next;
            d_addr_reg     <= d_addr_next;
            d_we_reg       <= d_we_next;
            d_wdata_reg    <= d_wdata_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Memory-side outputs depend only on state, so reset zeroes them immediately.
    always_comb begin
        i_gnt     = (state_reg == ACC_I);
        d_gnt     = (state_reg == ACC_D);
        mem_addr  = 5'd0;
        mem_w_en  = 1'b0;
        mem_wdata = 8'd0;
        case (state_reg)
            ACC_I: begin
                mem_addr = {1'b0, i_addr_reg};
            end
            ACC_D: begin
                mem_addr  = {1'b1, d_addr_reg};
                mem_w_en  = d_we_reg;
                mem_wdata = d_wdata_reg;
            end
            default: begin
                mem_addr = 5'd0;
            end
        endcase
    end

    // Read data is captured at the end of the grant cycle and held until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            i_rdata_reg  <= 8'd0;
            d_rdata_reg  <= 8'd0;
        end else begin
            i_rvalid_reg <= (state_reg == ACC_I);
            d_rvalid_reg <= (state_reg == ACC_D) && !d_we_reg;
            if (state_reg == ACC_I) begin
                i_rdata_reg <= mem_rdata;
            end
            if ((state_reg == ACC_D) && !d_we_reg) begin
                d_rdata_reg <= mem_rdata;
            end
        end
    end

    assign i_rvalid = i_rvalid_reg;
    assign d_rvalid = d_rvalid_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule
